// File: rtl/ibus_prefetch_buffer_if.sv
// Instruction-bus handshake bundle: request (valid/addr) and response (addr_ok/data_ok/data).
// Latency: none; plain wires.
// Backpressure: requester holds req_valid/req_addr until resp_addr_ok.
interface ibus_prefetch_buffer_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_addr_ok;
  logic              resp_data_ok;
  logic [DATA_W-1:0] resp_data;

  // Issuer of requests.
  modport master (
    output req_valid, req_addr,
    input  resp_addr_ok, resp_data_ok, resp_data
  );

  // Responder to requests.
  modport slave (
    input  req_valid, req_addr,
    output resp_addr_ok, resp_data_ok, resp_data
  );
endinterface

// File: rtl/ibus_prefetch_buffer.sv
// Sequential instruction prefetcher: PC-tagged FIFO between the core ibus and the memory ibus.
// Latency: FIFO-head hits answer combinationally; memory data reaches the core one cycle after
//          data_ok, or the same cycle when IBUS_PREFETCH_BYPASS_EN is defined and the core waits on it.
// Backpressure: one memory transaction outstanding; no new request while count + inflight == DEPTH.
module ibus_prefetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  ibus_prefetch_buffer_if.slave  core,
  ibus_prefetch_buffer_if.master mem
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [PW:0]       count, count_next;
  logic              stale, started, mreq_valid_q;
  logic [ADDR_W-1:0] nxt_pc, infl_pc;

  logic              creq_valid;
  logic [ADDR_W-1:0] creq_addr;
  logic              mresp_addr_ok, mresp_data_ok;
  logic [DATA_W-1:0] mresp_data;

  logic inflight, hit, wait_match, redirect, complete, bypass, push, pop, do_issue;

  assign creq_valid    = core.req_valid;
  assign creq_addr     = core.req_addr;
  assign mresp_addr_ok = mem.resp_addr_ok;
  assign mresp_data_ok = mem.resp_data_ok;
  assign mresp_data    = mem.resp_data;

  assign inflight   = (state != IDLE);
  assign hit        = creq_valid && (count != '0) && (pc_q[head] == creq_addr);
  // Core is parked on the fetch already in flight: not a redirect, just no answer yet.
  assign wait_match = (count == '0) && inflight && !stale && (infl_pc == creq_addr);
  assign redirect   = creq_valid && !hit && !wait_match;
  // Memory never returns data before addr_ok, so data_ok only counts in REQ (with addr_ok) or WAIT.
  assign complete   = ((state == REQ) && mresp_addr_ok && mresp_data_ok) ||
                      ((state == WAIT) && mresp_data_ok);

`ifdef IBUS_PREFETCH_BYPASS_EN
  assign bypass = complete && !stale && creq_valid && (count == '0) && (creq_addr == infl_pc);
`else
  assign bypass = 1'b0;
`endif

  // Data racing a redirect is dropped exactly like stale data.
  assign push = complete && !stale && !redirect && !bypass;
  assign pop  = hit;

  // Occupancy after this edge; a redirect empties the FIFO.
  always_comb begin
    count_next = count;
    if (redirect)
      count_next = '0;
    else if (push && !pop)
      count_next = count + (PW+1)'(1);
    else if (pop && !push)
      count_next = count - (PW+1)'(1);
  end

  // Issue from IDLE or straight out of a completion. A redirect to nxt_pc itself is safe to issue
  // because nxt_pc already holds the target; a redirect elsewhere waits one cycle for nxt_pc.
  assign do_issue = started && (count_next < FULL_CNT) && ((state == IDLE) || complete) &&
                    !(redirect && (creq_addr != nxt_pc));

  assign core.resp_addr_ok = hit || bypass;
  assign core.resp_data_ok = hit || bypass;
  assign core.resp_data    = bypass ? mresp_data : ((count != '0) ? instr_q[head] : '0);
  assign mem.req_valid     = mreq_valid_q;
  assign mem.req_addr      = infl_pc;

  // FIFO payload storage; contents only matter where count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail]    <= infl_pc;
      instr_q[tail] <= mresp_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count_next;
    end
  end

  // Memory-side FSM: issue, hold the request until addr_ok, completion and stale tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      mreq_valid_q <= 1'b0;
      infl_pc      <= '0;
      nxt_pc       <= '0;
      stale        <= 1'b0;
      started      <= 1'b0;
    end else begin
      if (creq_valid) started <= 1'b1;
      if (redirect)   nxt_pc  <= creq_addr;
      if (complete)
        stale <= 1'b0;
      else if (redirect && inflight)
        stale <= 1'b1;
      if (do_issue) begin
        state        <= REQ;
        mreq_valid_q <= 1'b1;
        infl_pc      <= nxt_pc;
        nxt_pc       <= nxt_pc + ADDR_W'(4);
      end else if (complete) begin
        state        <= IDLE;
        mreq_valid_q <= 1'b0;
      end else if ((state == REQ) && mresp_addr_ok) begin
        state        <= WAIT;
        mreq_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: doc/ibus_prefetch_buffer.md
Name: ibus_prefetch_buffer

Overview:
- Sits between the pipeline core's instruction bus port (ireq/iresp) and the memory-side instruction bus.
- Prefetches sequential 32-bit instructions into a small FIFO tagged with PC, and serves core fetches that hit the FIFO head in the same cycle.
- Any core fetch to a non-sequential address (a redirect) flushes the FIFO and restarts prefetch at that address.
- At most one memory transaction is outstanding at a time.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 64, address width.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; asynchronous, active-low (asserted when 0).
- creq_valid  in  1  core fetch request valid.
- creq_addr  in  ADDR_W  core fetch PC; 4-byte aligned.
- cresp_addr_ok  out  1  core request accepted.
- cresp_data_ok  out  1  cresp_data valid.
- cresp_data  out  DATA_W  instruction returned to the core.
- mreq_valid  out  1  memory request valid.
- mreq_addr  out  ADDR_W  memory request address.
- mresp_addr_ok  in  1  memory accepted the request.
- mresp_data_ok  in  1  memory returned data.
- mresp_data  in  DATA_W  memory data.

Behaviour:
- Reset values (asynchronous on reset=0): FIFO count=0, head/tail=0, state=IDLE, stale=0, nxt_pc=0; all outputs 0.
- FIFO entry = {pc, instr}. Define hit = creq_valid && count>0 && head.pc==creq_addr.
- Core side, combinational: cresp_addr_ok = cresp_data_ok = hit; cresp_data = head.instr. A hit pops the head at the clock edge.
- Redirect: creq_valid && !hit && !(count==0 && inflight && !stale && infl_pc==creq_addr).
  - At the edge: count=0, nxt_pc=creq_addr.
  - Any in-flight transaction is marked stale.
- Waiting on a matching in-flight fetch with an empty FIFO is not a redirect; the core simply sees no response.
- States: IDLE, REQ (mreq_valid=1, awaiting addr_ok), WAIT (awaiting data_ok).
  - IDLE -> REQ when count + inflight < DEPTH and the block has been started; issue address nxt_pc.
  - The block starts on the first creq_valid after reset. A redirect in IDLE issues in the following cycle.
  - REQ: mreq_addr is held stable and the request is never retracted, even if a redirect occurs.
  - REQ, addr_ok && !data_ok -> WAIT.
  - REQ, addr_ok && data_ok in the same cycle -> complete.
  - WAIT, data_ok -> complete.
  - On issue, infl_pc=nxt_pc and nxt_pc += 4 (wraps modulo 2^ADDR_W).
- Complete:
  - If !stale, push {infl_pc, mresp_data}.
  - If stale, discard the data and clear stale.
  - Then go to IDLE, or go directly to REQ if the prefetch condition still holds (no idle bubble).
- A push and a pop in the same cycle leave count unchanged.
- Full: no new request while count + inflight == DEPTH. An in-flight fetch always has a free slot reserved, so the FIFO never overflows.
- Redirect coinciding with data_ok: the data is discarded (treated as stale) and the FIFO is cleared.
- Latency without bypass: memory data_ok -> enqueue at the edge -> core hit the next cycle (1 cycle).
- Memory must not assert data_ok before addr_ok. Data arriving while in IDLE is ignored.

Optional Feature:
- Macro: IBUS_PREFETCH_BYPASS_EN.
- Defined: when count==0, the fetch is non-stale and completing this cycle, and creq_valid && creq_addr==infl_pc, the block forwards mresp_data to the core in the same cycle.
  - cresp_addr_ok = cresp_data_ok = 1 for that cycle.
  - The entry is not enqueued.
- Undefined: the data is always enqueued first, so the core sees it one cycle later.

Test Plan:
- Sequential stream: core requests 0x80000000, 0x80000004, ... and memory returns one cycle after addr_ok -> core gets correct instructions in order; after warm-up, one hit per cycle while the FIFO is non-empty.
- Fill/full: DEPTH=4, core stalls (creq_valid=0) after the first request -> exactly 4 memory requests (0x80000000–0x8000000C); mreq_valid stays 0 until a pop.
- Redirect mid-REQ: while a fetch of 0x80000008 waits for addr_ok, core requests 0x80001000 -> mreq_addr stays 0x80000008 until addr_ok; its data is discarded; the next request is 0x80001000; count=0 after the redirect.
- Same-cycle addr_ok+data_ok with a simultaneous pop on a full FIFO -> count unchanged, no overflow, next request is issued back-to-back.
- Reset mid-operation: assert reset=0 while in WAIT with 3 entries -> all outputs 0 immediately; after release, no request until creq_valid.
- Bypass: with IBUS_PREFETCH_BYPASS_EN defined, empty FIFO, core waiting on 0x80000000 and data_ok arrives -> cresp_data_ok=1 in the same cycle and count stays 0; without the macro -> response one cycle later.
